uart_rx_cfg: RTL

- Runtime-configurable UART receiver: succeeds the fixed 8N1 receiver; adds 5–8 data bits, optional even/odd parity, 1 or 2 stop bits, per-byte framing and parity error flags, break detection, and a first-word-fall-through RX FIFO with ready/valid read side.
- Sits between the pad-side serial input and the peripheral register/bus interface. Baud divisor is supplied at runtime.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_fifo_sync.sv | 53 +++++
 rtl/uart_rx_cfg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
    } state_e;

    localparam logic [1:0] DB_5 = 2'b00;
    localparam logic [1:0] DB_6 = 2'b01;
    localparam logic [1:0] DB_7 = 2'b10;
    localparam logic [1:0] DB_8 = 2'b11;

    localparam int ENTRY_W = 10;

    typedef struct packed {
        logic       frame_err;
        logic       parity_err;
        logic [7:0] data;
    } rx_entry_t;

    function automatic logic [3:0] data_bit_count(input logic [1:0] code);
        case (code)
            DB_5:    return 4'd5;
            DB_6:    return 4'd6;
            DB_7:    return 4'd7;
            DB_8:    return 4'd8;
            default: return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo_sync.sv
// First-word-fall-through synchronous FIFO; head is read straight from storage.
module uart_fifo_sync #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == FULL_LVL);
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem[rptr];
    assign level_o = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata_i;
                wptr      <= wptr + AW'(1);
            end
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5-8 data bits, parity, 1/2 stop bits)
// with break detection and an FWFT receive FIFO.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    input  logic                          rx_enable_i,
    input  logic [CNT_W-1:0]              clks_per_bit_i,
    input  logic [1:0]                    data_bits_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    input  logic                          clr_i,
    output logic [7:0]                    rdata_o,
    output logic                          frame_err_o,
    output logic                          parity_err_o,
    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic                          overflow_o,
    output logic                          break_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    state_e           state, state_d;
    logic             sync1, rxs;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       idx, idx_d;
    logic [7:0]       shreg, shreg_d;
    logic [CNT_W-1:0] cfg_cpb, cfg_cpb_d;
    logic [1:0]       cfg_db, cfg_db_d;
    logic             cfg_pen, cfg_pen_d, cfg_podd, cfg_podd_d, cfg_stop2, cfg_stop2_d;
    logic             par_bit, par_bit_d, par_err, par_err_d, ferr, ferr_d;
    logic             push_q, push_d, brk_q, brk_d;
    rx_entry_t        entry_q, entry_d, head;
    logic [ENTRY_W-1:0] head_raw;
    logic             complete, is_break, bit_tick;
    logic [CNT_W-1:0] cpb_m1, half_m1;
    logic [2:0]       last_idx;
    logic             fifo_empty, fifo_full, overflow_q;

    assign cpb_m1   = cfg_cpb - CNT_W'(1);
    assign half_m1  = cpb_m1 >> 1;
    assign last_idx = 3'(data_bit_count(cfg_db) - 4'd1);
    assign bit_tick = (cnt == cpb_m1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        shreg_d     = shreg;
        cfg_cpb_d   = cfg_cpb;
        cfg_db_d    = cfg_db;
        cfg_pen_d   = cfg_pen;
        cfg_podd_d  = cfg_podd;
        cfg_stop2_d = cfg_stop2;
        par_bit_d   = par_bit;
        par_err_d   = par_err;
        ferr_d      = ferr;
        entry_d     = entry_q;
        push_d      = 1'b0;
        brk_d       = 1'b0;
        complete    = 1'b0;
        is_break    = 1'b0;

        if (state inside {DATA, PARITY, STOP1, STOP2})
            cnt_d = bit_tick ? '0 : cnt + CNT_W'(1);

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_enable_i && !rxs) begin
                    state_d     = START;
                    shreg_d     = '0;
                    par_bit_d   = 1'b0;
                    par_err_d   = 1'b0;
                    ferr_d      = 1'b0;
                    cfg_cpb_d   = clks_per_bit_i;
                    cfg_db_d    = data_bits_i;
                    cfg_pen_d   = parity_en_i;
                    cfg_podd_d  = parity_odd_i;
                    cfg_stop2_d = stop2_i;
                end
            end
            START: begin
                if (cnt == half_m1) begin
                    cnt_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: if (bit_tick) begin
                shreg_d[idx] = rxs;
                if (idx == last_idx) begin
                    idx_d   = '0;
                    state_d = cfg_pen ? PARITY : STOP1;
                end else begin
                    idx_d = idx + 3'd1;
                end
            end
            PARITY: if (bit_tick) begin
                par_bit_d = rxs;
                par_err_d = (((^shreg) ^ rxs) != cfg_podd);
                state_d   = STOP1;
            end
            STOP1: if (bit_tick) begin
                ferr_d = !rxs;
                if (cfg_stop2) state_d = STOP2;
                else           complete = 1'b1;
            end
            STOP2: if (bit_tick) begin
                ferr_d   = ferr | !rxs;
                complete = 1'b1;
            end
            WAIT_HIGH: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A break is an all-zero frame; it is flagged, never queued.
        if (complete) begin
            is_break           = (shreg == '0) && !par_bit && ferr_d;
            brk_d              = is_break;
            push_d             = !is_break && !clr_i;
            entry_d.frame_err  = ferr_d;
            entry_d.parity_err = par_err;
            entry_d.data       = shreg;
            state_d            = ferr_d ? WAIT_HIGH : IDLE;
        end

        if (!rx_enable_i && state != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            push_d  = 1'b0;
            brk_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            cfg_cpb   <= '0;
            cfg_db    <= '0;
            cfg_pen   <= 1'b0;
            cfg_podd  <= 1'b0;
            cfg_stop2 <= 1'b0;
            par_bit   <= 1'b0;
            par_err   <= 1'b0;
            ferr      <= 1'b0;
            entry_q   <= '0;
            push_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            shreg     <= shreg_d;
            cfg_cpb   <= cfg_cpb_d;
            cfg_db    <= cfg_db_d;
            cfg_pen   <= cfg_pen_d;
            cfg_podd  <= cfg_podd_d;
            cfg_stop2 <= cfg_stop2_d;
            par_bit   <= par_bit_d;
            par_err   <= par_err_d;
            ferr      <= ferr_d;
            entry_q   <= entry_d;
            push_q    <= push_d;
            brk_q     <= brk_d;
        end
    end

    uart_fifo_sync #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (clr_i),
        .push_i  (push_q),
        .wdata_i (entry_q),
        .pop_i   (rready_i),
        .rdata_o (head_raw),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (level_o)
    );

    // Overflow only when the full FIFO is not being drained this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                               overflow_q <= 1'b0;
        else if (clr_i)                            overflow_q <= 1'b0;
        else if (push_q && fifo_full && !rready_i) overflow_q <= 1'b1;
    end

    assign head         = rx_entry_t'(head_raw);
    assign rdata_o      = head.data;
    assign frame_err_o  = head.frame_err;
    assign parity_err_o = head.parity_err;
    assign rvalid_o     = !fifo_empty;
    assign overflow_o   = overflow_q;
    assign break_o      = brk_q;

endmodule
